alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Front-end controller for the ALU. Accepts one operation per valid/ready handshake and
//  routes single-cycle ops (NOT/AND/OR/ADD/SUB/NEG/shifts/rotates) to the combinational ALU.
//  Runs MUL/DIV itself as 32-step iterative operations. Returns a 64-bit result through a
//  valid/ready handshake, so the control unit can stall on long ops.
// PARAMETERS
//  WIDTH      32  operand width; result is 2*WIDTH
//  ITER_CNT   32  iteration steps for MUL/DIV (must equal WIDTH)
// PORTS
//  clock          in   1        system clock, rising edge
//  reset_n        in   1        asynchronous, active-low reset
//  req_valid      in   1        request present
//  req_ready      out  1        sequencer can accept (IDLE only)
//  req_op         in   5        opcode (ALU 5-bit encoding)
//  req_a, req_b   in   WIDTH    operands
//  flush          in   1        abort in-flight op, discard result
//  alu_op         out  5        opcode driven to ALU
//  alu_a, alu_b   out  WIDTH    operands driven to ALU
//  alu_out        in   2*WIDTH  ALU result
//  alu_finished   in   1        ALU result valid
//  res_valid      out  1        result available
//  res_ready      in   1        consumer takes result
//  res_data       out  2*WIDTH  {HI,LO}: MUL=product; DIV={remainder,quotient}
//  res_div0       out  1        DIV with B==0
//  res_illegal    out  1        unknown opcode
//  busy           out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; req_ready=1 after release; res_valid=0;
//    res_data=0; res_div0=0; res_illegal=0; alu_op=0; alu_a=0; alu_b=0; busy=0.
//  - Accept occurs on a clock edge with req_valid&req_ready. Operands and op are registered.
//    req_ready=0 in every state except IDLE.
//  - FSM: IDLE -> DISPATCH (single-cycle op) | ITER (MUL/DIV) | DONE (illegal op or DIV B==0).
//    DISPATCH -> DONE when alu_finished=1; stays in DISPATCH while alu_finished=0.
//    ITER -> DONE after ITER_CNT steps. DONE -> IDLE on res_ready.
//  - Latency (accept edge = cycle 0): single-cycle op: res_valid at cycle 2 with alu_finished
//    high in cycle 1. MUL/DIV: res_valid at cycle ITER_CNT+2. Illegal op or DIV0: cycle 1.
//  - DISPATCH: alu_op/alu_a/alu_b hold the registered values. Sample alu_out when
//    alu_finished=1. Outside DISPATCH, alu_op=0 (no-op).
//  - MUL: signed two's-complement shift-add, 1 step/cycle, full 2*WIDTH product.
//    Example: 0xFFFFFFFF*2 = 0xFFFFFFFF_FFFFFFFE.
//  - DIV: signed restoring division on magnitudes, 1 step/cycle.
//    Quotient sign = sign(A)^sign(B); remainder takes sign(A). Quotient truncates toward zero.
//  - DIV B==0: res_data={A, 32'hFFFFFFFF}; res_div0=1; no iterations.
//  - Illegal opcode: res_data=0; res_illegal=1.
//  - res_valid, res_data and flags stay stable until res_ready. The transfer completes on
//    the edge where res_valid&res_ready; res_valid drops next cycle.
//  - A new request is not accepted in the DONE/IDLE handoff cycle; req_ready rises the cycle
//    after the transfer.
//  - flush: in any non-IDLE state, next state=IDLE, res_valid=0, result discarded.
//    flush has priority over res_ready and alu_finished in the same cycle.
//    flush in IDLE is ignored, and a request in that cycle is still accepted.
//  - reset_n low mid-operation: immediate return to reset values; partial result lost.
//  - The iteration counter wraps only via reload on accept. No overflow flag on MUL/DIV.
// STRUCTURE
//  - Shared header alu_defs.vh: opcode constants (NOT..SHLA, MUL, DIV) and FSM state
//    encodings. Both ALU and sequencer include it.
//  - One sub-module: alu_iterative_muldiv (start, is_div, a, b -> done, hi, lo), holding the
//    shift/accumulate registers and the step counter. The FSM and handshakes stay in the parent.
// TESTING
//  1 Reset: hold reset_n=0 mid-MUL at cycle 10 -> all outputs 0 immediately; req_ready=1
//    after release.
//  2 AND A=0xF0F0F0F0 B=0xFF00FF00, stub ALU finishing in 1 cycle -> res_valid at cycle 2,
//    res_data=0x00000000_F000F000.
//  3 MUL A=-3 B=7 -> res_valid at cycle 34, res_data=0xFFFFFFFF_FFFFFFEB.
//    With res_ready=0 for 5 cycles, data stays stable.
//  4 DIV A=-7 B=2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF).
//    DIV A=5 B=0 -> cycle 1, res_div0=1, res_data=0x00000005_FFFFFFFF.
//  5 flush at cycle 15 of a DIV -> IDLE next cycle, no res_valid.
//    A back-to-back OR request is then accepted and completes correctly.
//  6 Opcode 5'b10000 -> res_illegal=1, res_data=0.
//    ALU stub holding alu_finished low 4 cycles -> sequencer stays in DISPATCH, then completes.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode encodings and FSM state type for the ALU op sequencer.
// Opcode 0 is the ALU no-op and is therefore not a legal request.
package alu_op_sequencer_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_ITER_CNT = 32;

    localparam logic [4:0] OP_NOT  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_NEG  = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SHR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_SHRA = 5'd11;
    localparam logic [4:0] OP_SHLA = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd13;
    localparam logic [4:0] OP_DIV  = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_ITER     = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_e;

    function automatic logic is_single_cycle(input logic [4:0] op);
        return (op >= OP_NOT) && (op <= OP_SHLA);
    endfunction

endpackage

// File: rtl/alu_iterative_muldiv.sv
// Iterative signed MUL (shift-add) / DIV (restoring) on operand magnitudes,
// one step per clock; signs are re-applied combinationally on the outputs.
module alu_iterative_muldiv #(
    parameter int WIDTH    = 32,
    parameter int ITER_CNT = 32
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(ITER_CNT + 1);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_m;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
        w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_m};
        w_prod  = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (i_start) begin
            r_hi     <= '0;
            r_lo     <= w_abs_a;
            r_m      <= w_abs_b;
            r_cnt    <= CW'(ITER_CNT);
            r_is_div <= i_is_div;
            r_neg_q  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_neg_r  <= i_a[WIDTH-1];
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_is_div) begin
                // Restoring step: keep the trial subtraction only if it did not borrow.
                if (!w_diff[WIDTH]) begin
                    r_hi <= w_diff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        o_done = (r_cnt == '0);
        o_hi   = w_prod[2*WIDTH-1:WIDTH];
        o_lo   = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            o_hi = r_neg_r ? -r_hi : r_hi;
            o_lo = r_neg_q ? -r_lo : r_lo;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front-end: accepts one op per handshake, dispatches single-cycle ops to the
// external ALU, runs MUL/DIV iteratively, and holds the result until consumed.
//  state    | meaning
//  IDLE     | ready for a request
//  DISPATCH | op/operands driven to ALU, waiting for alu_finished
//  ITER     | MUL/DIV stepping in alu_iterative_muldiv
//  DONE     | result valid, waiting for res_ready
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ITER_CNT = DEF_ITER_CNT
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [4:0]         i_req_op,
    input  logic [WIDTH-1:0]   i_req_a,
    input  logic [WIDTH-1:0]   i_req_b,
    input  logic               i_flush,
    output logic [4:0]         o_alu_op,
    output logic [WIDTH-1:0]   o_alu_a,
    output logic [WIDTH-1:0]   o_alu_b,
    input  logic [2*WIDTH-1:0] i_alu_out,
    input  logic               i_alu_finished,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [2*WIDTH-1:0] o_res_data,
    output logic               o_res_div0,
    output logic               o_res_illegal,
    output logic               o_busy
);
    seq_state_e         r_state;
    logic               r_req_ready;
    logic               r_res_valid;
    logic [2*WIDTH-1:0] r_res_data;
    logic               r_div0;
    logic               r_illegal;
    logic [4:0]         r_alu_op;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic               r_busy;

    logic               w_accept;
    logic               w_b_zero;
    logic               w_md_start;
    logic               w_md_done;
    logic [WIDTH-1:0]   w_md_hi;
    logic [WIDTH-1:0]   w_md_lo;

    assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
    assign w_b_zero   = (i_req_b == '0);
    assign w_md_start = w_accept && ((i_req_op == OP_MUL) || ((i_req_op == OP_DIV) && !w_b_zero));

    alu_iterative_muldiv #(
        .WIDTH    (WIDTH),
        .ITER_CNT (ITER_CNT)
    ) u_muldiv (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_start   (w_md_start),
        .i_is_div  (i_req_op == OP_DIV),
        .i_a       (i_req_a),
        .i_b       (i_req_b),
        .o_done    (w_md_done),
        .o_hi      (w_md_hi),
        .o_lo      (w_md_lo)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_busy      <= 1'b0;
        end else if (i_flush && (r_state != ST_IDLE)) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_div0      <= 1'b0;
                        r_illegal   <= 1'b0;
                        if (is_single_cycle(i_req_op)) begin
                            r_state  <= ST_DISPATCH;
                            r_alu_op <= i_req_op;
                            r_alu_a  <= i_req_a;
                            r_alu_b  <= i_req_b;
                        end else if (w_md_start) begin
                            r_state <= ST_ITER;
                        end else if (i_req_op == OP_DIV) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                            r_res_data  <= {i_req_a, {WIDTH{1'b1}}};
                            r_div0      <= 1'b1;
                        end else begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                            r_res_data  <= '0;
                            r_illegal   <= 1'b1;
                        end
                    end
                end
                ST_DISPATCH: begin
                    if (i_alu_finished) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res_data  <= i_alu_out;
                        r_alu_op    <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                    end
                end
                ST_ITER: begin
                    if (w_md_done) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res_data  <= {w_md_hi, w_md_lo};
                    end
                end
                ST_DONE: begin
                    if (i_res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_res_valid   = r_res_valid;
    assign o_res_data    = r_res_data;
    assign o_res_div0    = r_div0;
    assign o_res_illegal = r_illegal;
    assign o_alu_op      = r_alu_op;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_busy        = r_busy;

endmodule
